kosei_volume_ramp_ctrl: RTL and testbench

//   Gain sequencer for the stereo I2S playback path. Holds per-channel target

---
 rtl/kosei_volume_ramp_ctrl.sv | 171 +++++++++++++++++
 tb/tb_kosei_volume_ramp_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kosei_volume_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : kosei_volume_ramp_ctrl
// Brief    : Click-free stereo gain sequencer. Ramps live gains toward targets
//            one step per sample_tick, with soft mute and bypass.
// Revision : 1.0
// ============================================================================
module kosei_volume_ramp_ctrl #(
  parameter int               VOL_W        = 8,
  parameter logic [VOL_W-1:0] RESET_VOL    = {VOL_W{1'b1}},
  parameter logic [VOL_W-1:0] STEP_DEFAULT = VOL_W'(1)
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             sample_tick,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_addr,
  input  logic [VOL_W-1:0] cfg_wdata,
  output logic [VOL_W-1:0] gain_left,
  output logic [VOL_W-1:0] gain_right,
  output logic             gain_update,
  output logic             ramp_busy,
  output logic             muted
);

  localparam logic [VOL_W-1:0] c_step_min = VOL_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RAMP   = 2'd1,
    S_MUTING = 2'd2,
    S_MUTED  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [VOL_W-1:0] r_tgt_l;
  logic [VOL_W-1:0] r_tgt_r;
  logic [VOL_W-1:0] r_step;
  logic             r_mute;
  logic             r_bypass;
  logic [VOL_W-1:0] r_cur_l;
  logic [VOL_W-1:0] r_cur_r;
  logic             r_gain_update;

  logic [VOL_W-1:0] w_eff_l;
  logic [VOL_W-1:0] w_eff_r;
  logic [VOL_W-1:0] w_step_eff;
  logic [VOL_W-1:0] w_nxt_l;
  logic [VOL_W-1:0] w_nxt_r;
  logic             w_cfg_fire;
  logic             w_match;
  logic             w_cur_zero;
  logic             w_eff_zero;

  // Sums and differences carry one extra bit so saturation is detected
  // before the result can wrap past zero or full scale.
  function automatic logic [VOL_W-1:0] f_ramp(
    input logic [VOL_W-1:0] cur,
    input logic [VOL_W-1:0] eff,
    input logic [VOL_W-1:0] stp,
    input logic             byp
  );
    logic [VOL_W:0] sum;
    logic [VOL_W:0] dif;
    sum    = {1'b0, cur} + {1'b0, stp};
    dif    = {1'b0, cur} - {1'b0, stp};
    f_ramp = cur;
    if (byp) begin
      f_ramp = eff;
    end else if (cur < eff) begin
      f_ramp = (sum > {1'b0, eff}) ? eff : sum[VOL_W-1:0];
    end else if (cur > eff) begin
      f_ramp = (dif[VOL_W] || (dif[VOL_W-1:0] < eff)) ? eff : dif[VOL_W-1:0];
    end
  endfunction

  assign w_eff_l    = r_mute ? '0 : r_tgt_l;
  assign w_eff_r    = r_mute ? '0 : r_tgt_r;
  assign w_step_eff = (r_step == '0) ? c_step_min : r_step;
  assign w_nxt_l    = f_ramp(r_cur_l, w_eff_l, w_step_eff, r_bypass);
  assign w_nxt_r    = f_ramp(r_cur_r, w_eff_r, w_step_eff, r_bypass);
  assign w_cfg_fire = cfg_valid & cfg_ready;
  assign w_match    = (r_cur_l == w_eff_l) && (r_cur_r == w_eff_r);
  assign w_cur_zero = (r_cur_l == '0) && (r_cur_r == '0);
  assign w_eff_zero = (w_eff_l == '0) && (w_eff_r == '0);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_tgt_l  <= RESET_VOL;
      r_tgt_r  <= RESET_VOL;
      r_step   <= STEP_DEFAULT;
      r_mute   <= 1'b0;
      r_bypass <= 1'b0;
    end else if (w_cfg_fire) begin
      case (cfg_addr)
        2'd0:    r_tgt_l <= cfg_wdata;
        2'd1:    r_tgt_r <= cfg_wdata;
        2'd2:    r_step  <= cfg_wdata;
        default: begin
          r_mute   <= cfg_wdata[0];
          r_bypass <= cfg_wdata[1];
        end
      endcase
    end
  end

  // The ramp reads the pre-write registers, so a write colliding with a tick
  // only affects the following tick.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_l       <= '0;
      r_cur_r       <= '0;
      r_gain_update <= 1'b0;
    end else if (sample_tick) begin
      r_cur_l       <= w_nxt_l;
      r_cur_r       <= w_nxt_r;
      r_gain_update <= (w_nxt_l != r_cur_l) || (w_nxt_r != r_cur_r);
    end else begin
      r_gain_update <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_mute) begin
          w_state_nxt = w_cur_zero ? S_MUTED : S_MUTING;
        end else if (!w_match) begin
          w_state_nxt = S_RAMP;
        end
      end
      S_RAMP: begin
        if (r_mute) begin
          w_state_nxt = S_MUTING;
        end else if (w_match) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_MUTING: begin
        if (w_cur_zero) begin
          w_state_nxt = S_MUTED;
        end
      end
      default: begin
        if (!r_mute) begin
          w_state_nxt = w_eff_zero ? S_IDLE : S_RAMP;
        end
      end
    endcase
  end

  assign cfg_ready   = (r_state != S_MUTING);
  assign ramp_busy   = (r_state == S_RAMP) || (r_state == S_MUTING);
  assign muted       = (r_state == S_MUTED);
  assign gain_left   = r_cur_l;
  assign gain_right  = r_cur_r;
  assign gain_update = r_gain_update;

endmodule
`default_nettype wire

// File: tb/tb_kosei_volume_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_kosei_volume_ramp_ctrl
// Brief    : Scoreboard bench for kosei_volume_ramp_ctrl with a frame-level
//            gain model and randomized config/tick traffic.
// Revision : 1.0
// ============================================================================
module tb_kosei_volume_ramp_ctrl;

  logic       clk_sys     = 1'b0;
  logic       rst_n       = 1'b0;
  logic       sample_tick = 1'b0;
  logic       cfg_valid   = 1'b0;
  logic [1:0] cfg_addr    = 2'd0;
  logic [7:0] cfg_wdata   = 8'd0;
  logic       cfg_ready;
  logic [7:0] gain_left;
  logic [7:0] gain_right;
  logic       gain_update;
  logic       ramp_busy;
  logic       muted;

  kosei_volume_ramp_ctrl dut (
    .clk_sys     (clk_sys),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .gain_left   (gain_left),
    .gain_right  (gain_right),
    .gain_update (gain_update),
    .ramp_busy   (ramp_busy),
    .muted       (muted)
  );

  always #5 clk_sys = ~clk_sys;

  int vectors = 0;
  int errors  = 0;

  // Frame-level model: targets, step, control bits and the live gains.
  int          m_tgt [2];
  int          m_cur [2];
  int          m_step;
  bit          m_mute;
  bit          m_byp;
  logic [15:0] exp_q[$];
  logic [15:0] mon_e;
  logic [7:0]  last_l, last_r;
  int          seen_pulses;
  bit          muted_at_neg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int approach(input int cur, input int eff, input int stp, input bit byp);
    int s;
    s = (stp == 0) ? 1 : stp;
    if (byp)        return eff;
    if (cur < eff)  return (cur + s > eff) ? eff : cur + s;
    if (cur > eff)  return (cur - s < eff) ? eff : cur - s;
    return cur;
  endfunction

  task automatic model_reset();
    m_tgt[0] = 255; m_tgt[1] = 255;
    m_cur[0] = 0;   m_cur[1] = 0;
    m_step = 1; m_mute = 0; m_byp = 0;
    exp_q.delete();
    last_l = 8'h00; last_r = 8'h00;
  endtask

  task automatic model_tick();
    int n [2];
    for (int ch = 0; ch < 2; ch++)
      n[ch] = approach(m_cur[ch], m_mute ? 0 : m_tgt[ch], m_step, m_byp);
    if (n[0] != m_cur[0] || n[1] != m_cur[1])
      exp_q.push_back({n[0][7:0], n[1][7:0]});
    m_cur[0] = n[0];
    m_cur[1] = n[1];
  endtask

  task automatic model_write(input logic [1:0] a, input logic [7:0] d);
    case (a)
      2'd0: m_tgt[0] = int'(d);
      2'd1: m_tgt[1] = int'(d);
      2'd2: m_step   = int'(d);
      default: begin m_mute = d[0]; m_byp = d[1]; end
    endcase
  endtask

  // Monitor: every gain_update pops one expected gain pair; otherwise gains hold.
  always @(negedge clk_sys) begin
    if (rst_n) begin
      if (gain_update) begin
        seen_pulses++;
        if (exp_q.size() == 0) begin
          chk("unexpected_update", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("gain_left", gain_left, mon_e[15:8]);
          chk("gain_right", gain_right, mon_e[7:0]);
          last_l = mon_e[15:8];
          last_r = mon_e[7:0];
        end
      end else begin
        chk("hold_left", gain_left, last_l);
        chk("hold_right", gain_right, last_r);
      end
    end
  end

  // One clock cycle of stimulus; entered and left at posedge+1.
  task automatic cycle(input bit tk, input bit wr, input logic [1:0] a,
                       input logic [7:0] d, output bit acc);
    sample_tick = tk;
    cfg_valid   = wr;
    cfg_addr    = a;
    cfg_wdata   = d;
    @(negedge clk_sys);
    acc          = wr && cfg_ready;
    muted_at_neg = muted;
    @(posedge clk_sys);
    if (tk)  model_tick();
    if (acc) model_write(a, d);
    #1;
    sample_tick = 1'b0;
    cfg_valid   = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'd0, 8'd0, acc);
  endtask

  task automatic tick(input int n);
    bit acc;
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, 1'b0, 2'd0, 8'd0, acc);
      cycle(1'b0, 1'b0, 2'd0, 8'd0, acc);
    end
  endtask

  // Holds a write until accepted, ticking every other cycle while stalled.
  task automatic wr(input logic [1:0] a, input logic [7:0] d, output bit acc_muted);
    bit acc;
    acc = 0;
    acc_muted = 0;
    for (int k = 0; k < 64 && !acc; k++) begin
      cycle(k % 2 == 1, 1'b1, a, d, acc);
      acc_muted = muted_at_neg;
    end
    if (!acc) chk("write_timeout", 32'd0, 32'd1);
  endtask

  task automatic wrq(input logic [1:0] a, input logic [7:0] d);
    bit dummy;
    wr(a, d, dummy);
  endtask

  // Status after a few quiet cycles follows from the model alone.
  task automatic check_status(input string tag);
    bit any_nonzero, any_mismatch;
    idle(3);
    any_nonzero  = (m_cur[0] != 0) || (m_cur[1] != 0);
    any_mismatch = (m_cur[0] != (m_mute ? 0 : m_tgt[0])) ||
                   (m_cur[1] != (m_mute ? 0 : m_tgt[1]));
    if (m_mute) begin
      chk({tag, "_busy"},  ramp_busy, any_nonzero);
      chk({tag, "_muted"}, muted,     !any_nonzero);
      chk({tag, "_ready"}, cfg_ready, !any_nonzero);
    end else begin
      chk({tag, "_busy"},  ramp_busy, any_mismatch);
      chk({tag, "_muted"}, muted,     1'b0);
      chk({tag, "_ready"}, cfg_ready, 1'b1);
    end
    chk({tag, "_drained"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc, am;
    logic [1:0] a;
    logic [7:0] d;
    model_reset();
    seen_pulses = 0;
    #12;
    chk("rst_gain_left",  gain_left,   8'h00);
    chk("rst_gain_right", gain_right,  8'h00);
    chk("rst_busy",       ramp_busy,   1'b0);
    chk("rst_muted",      muted,       1'b0);
    chk("rst_ready",      cfg_ready,   1'b1);
    chk("rst_update",     gain_update, 1'b0);
    @(posedge clk_sys); #2; rst_n = 1'b1;
    @(posedge clk_sys); #1;

    // Power-up fade-in.
    for (int i = 1; i <= 256; i++) begin
      tick(1);
      if (i == 200) chk("t1_busy_mid", ramp_busy, 1'b1);
    end
    check_status("t1");
    chk("t1_pulses", seen_pulses, 32'd255);
    chk("t1_final_l", gain_left, 8'hFF);

    // Down-ramp with saturation at the target.
    wrq(2'd2, 8'h20);
    wrq(2'd0, 8'h10);
    tick(10);
    check_status("t2");
    chk("t2_final_l", gain_left, 8'h10);

    // Soft mute from 0x80 with a write held off until MUTED.
    wrq(2'd3, 8'h02);
    wrq(2'd0, 8'h80);
    wrq(2'd1, 8'h80);
    tick(1);
    wrq(2'd3, 8'h00);
    wrq(2'd2, 8'h40);
    check_status("t3_pre");
    wrq(2'd3, 8'h01);
    idle(1);
    chk("t3_ready_muting", cfg_ready, 1'b0);
    wr(2'd0, 8'h80, am);
    chk("t3_accept_in_muted", am, 1'b1);
    check_status("t3");
    wrq(2'd3, 8'h00);
    tick(3);
    check_status("t3_unmute");

    // Write colliding with a tick.
    wrq(2'd2, 8'h01);
    wrq(2'd0, 8'hFF);
    cycle(1'b1, 1'b1, 2'd0, 8'h00, acc);
    chk("t4_collision_tick", gain_left, 8'h81);
    idle(1);
    tick(1);
    chk("t4_next_tick", gain_left, 8'h80);

    // Bypass, then step 0 behaving as 1.
    wrq(2'd3, 8'h02);
    wrq(2'd1, 8'h33);
    tick(1);
    chk("t5_bypass_r", gain_right, 8'h33);
    wrq(2'd3, 8'h00);
    wrq(2'd2, 8'h00);
    wrq(2'd1, 8'h35);
    tick(1);
    chk("t5_step0_a", gain_right, 8'h34);
    tick(1);
    chk("t5_step0_b", gain_right, 8'h35);
    check_status("t5");

    // Randomized traffic; single-cycle write attempts may be refused.
    for (int i = 0; i < 600; i++) begin
      a = 2'($urandom_range(0, 3));
      d = 8'($urandom_range(0, 255));
      cycle($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, a, d, acc);
      if (i % 150 == 149) check_status("rand");
    end
    check_status("rand_end");

    // Reset in the middle of a ramp.
    wrq(2'd3, 8'h02);
    wrq(2'd0, 8'h80);
    wrq(2'd1, 8'h80);
    tick(1);
    wrq(2'd3, 8'h00);
    wrq(2'd2, 8'h01);
    wrq(2'd0, 8'h00);
    tick(2);
    chk("t6_busy_before", ramp_busy, 1'b1);
    @(negedge clk_sys); #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_gain_left",  gain_left,  8'h00);
    chk("t6_gain_right", gain_right, 8'h00);
    chk("t6_busy",       ramp_busy,  1'b0);
    chk("t6_ready",      cfg_ready,  1'b1);
    @(posedge clk_sys); #2; rst_n = 1'b1;
    @(posedge clk_sys); #1;
    tick(3);
    chk("t6_restart_l", gain_left, 8'h03);
    check_status("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
